// File: rtl/seq_mon_pkg.sv
// Shared definitions for the sequence-match rate monitor: FSM encoding,
// default widths and the saturating increment used by the detection counter.
package seq_mon_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int DEF_WIN_W = 8;
  localparam int DEF_CNT_W = 6;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] maxv;
    maxv = (32'd1 << w) - 32'd1;
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_mon_sat_cnt.sv
// Saturating detection counter with synchronous clear; exposes the value it
// would hold after this cycle's increment so a window close can use it directly.
module seq_mon_sat_cnt
  import seq_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    cnt_nxt = cnt;
    if (inc) cnt_nxt = CNT_W'(sat_inc(32'(cnt), CNT_W));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt_nxt;
  end

endmodule

// File: rtl/seq_match_monitor.sv
// Counts match pulses over a programmable window and publishes each window's
// count on a valid/ready port, with overrun tracking and a threshold alarm.
module seq_match_monitor
  import seq_mon_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] res_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_overrun,
  output logic             alarm
);

  state_t           state, state_nxt;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_load;
  logic [CNT_W-1:0] final_cnt;
  logic             counting;
  logic             close;
  logic             det_clr;
  logic             det_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    counting  = 1'b0;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (en) counting  = 1'b1;
        else    state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A zero window length behaves as a one-cycle window.
  assign win_load = (win_len == '0) ? WIN_W'(1) : win_len;
  assign close    = counting && (win_cnt == WIN_W'(1));
  assign det_inc  = counting && z;
  assign det_clr  = !counting || close;

  seq_mon_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_det_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (det_clr),
    .inc    (det_inc),
    .cnt_nxt(final_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    win_cnt <= '0;
    else if ((state == ST_IDLE && en) || close)  win_cnt <= win_load;
    else if (counting)                           win_cnt <= win_cnt - WIN_W'(1);
  end

  // A close outranks an accept on the same edge; overrun only if the old result was not taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_count   <= '0;
      res_valid   <= 1'b0;
      res_overrun <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      alarm <= close && (thresh != '0) && (final_cnt >= thresh);
      if (close) begin
        res_count   <= final_cnt;
        res_valid   <= 1'b1;
        res_overrun <= res_valid && !res_ready;
      end else if (res_valid && res_ready) begin
        res_valid   <= 1'b0;
        res_overrun <= 1'b0;
      end
    end
  end

endmodule
